imem_fetch_arbiter: RTL and testbench
=====================================

Name: imem_fetch_arbiter

Overview:
- Shares one external instruction-memory port among all SIMD cores' fetch units.
- Arbitrates with work-conserving round-robin and issues at most one request per cycle.
- Tracks outstanding requests in an in-order ID FIFO and routes each returning instruction word to the core that requested it.
- Sits between the simd_core array's fetch ports and the single IMEM interface at GPU top level.

Parameters:
- NUM_SIMD_CORES, 4, number of requesting cores.
- LOG2_SIMD_CORES, 2, width of a core ID; ceil(log2(NUM_SIMD_CORES)).
- MAX_OUTSTANDING, 4, depth of the in-flight ID FIFO; power of two, at least 2.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- fetch_req  in  [NUM_SIMD_CORES-1:0]  per-core request; held until granted.
- fetch_addr  in  [31:0] x NUM_SIMD_CORES  per-core PC; stable while fetch_req is high.
- fetch_gnt  out  [NUM_SIMD_CORES-1:0]  one-hot, combinational; high in the cycle the core's request is sent to memory.
- fetch_rvalid  out  [NUM_SIMD_CORES-1:0]  registered, one-hot; instruction returned to that core.
- fetch_rdata  out  [31:0] x NUM_SIMD_CORES  registered; valid only where fetch_rvalid is high, otherwise 0.
- mem_req_valid  out  1  combinational; a request is presented.
- mem_req_ready  in  1  memory accepts the request this cycle.
- mem_addr  out  [31:0]  combinational; address of the selected request.
- mem_rvalid  in  1  in-order read response is valid.
- mem_rdata  in  [31:0]  read response data.
- protocol_error  out  1  registered, sticky; a response arrived with no request outstanding.

Behaviour:
- Reset: rr_ptr=NUM_SIMD_CORES-1; FIFO head, tail and count=0; fetch_rvalid=0; fetch_rdata all 0; protocol_error=0. Combinational outputs are 0 because no candidate is eligible.
- Eligibility: can_issue = (count < MAX_OUTSTANDING). A same-cycle pop does not free a slot for a same-cycle issue.
- Arbitration: scan cores starting at rr_ptr+1 (mod NUM_SIMD_CORES) and select the first with fetch_req high.
  - mem_req_valid = can_issue && |fetch_req.
  - mem_addr = fetch_addr[sel] when mem_req_valid is high, else 0.
- Fire = mem_req_valid && mem_req_ready.
  - On fire: fetch_gnt[sel]=1, push sel into the FIFO, rr_ptr<=sel.
  - Without fire: fetch_gnt=0 and rr_ptr is unchanged.
  - With mem_req_ready low, the selection may change between cycles as requests change. No lock is held.
- Response: when mem_rvalid is high and count>0, pop the head ID h. Next cycle fetch_rvalid[h]=1 and fetch_rdata[h]=mem_rdata; all other lanes are 0.
  - Latency is one cycle from mem_rvalid to fetch_rvalid.
  - Minimum round trip is fire at cycle N, mem_rvalid at N+1, fetch_rvalid at N+2.
- Spurious response: mem_rvalid high with count==0 causes no pop, no fetch_rvalid, and protocol_error<=1 until rst.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Wrap-around: pointers wrap modulo MAX_OUTSTANDING.
- Full FIFO: mem_req_valid=0 and fetch_gnt=0. Requests are held by the cores.
- Reset mid-operation: everything in flight is discarded. Memory responses that arrive after reset are treated as spurious and set protocol_error, so the integrator must reset memory together with this block.
- A core may have several requests in flight. Responses return in issue order.

Decomposition:
- Add to the shared parameters package: MAX_OUTSTANDING; typedef core_id_t = logic [LOG2_SIMD_CORES-1:0]; typedef fetch_rsp_t {valid, data[31:0]}.
- Natural sub-module: rr_arbiter, parameterised on N. Inputs are req and ptr; outputs are the one-hot gnt and the encoded sel.
- The ID FIFO stays inline in this block.

Test Plan:
- Single core 2 requests addr 0x100 with mem_req_ready=1, memory returns 0xDEADBEEF one cycle later -> fetch_gnt=4'b0100 at cycle N; fetch_rvalid=4'b0100 and fetch_rdata[2]=0xDEADBEEF at N+2; other lanes stay 0.
- All four cores request continuously, ready=1, responses one cycle after issue -> grant order 0,1,2,3,0,1; each fetch_rdata matches that core's address tag; count never exceeds 2.
- Hold mem_rvalid=0 while all cores request -> exactly 4 grants, then mem_req_valid=0. Release 4 responses A,B,C,D -> routed to cores 0,1,2,3 in order; granting resumes at core 0.
- FIFO full with simultaneous mem_rvalid and requests pending -> no grant that cycle (count drops to 3); grant occurs the next cycle.
- mem_rvalid pulse at count=0 -> protocol_error=1 next cycle and stays high; fetch_rvalid=0; cleared only by rst.
- Assert rst with 3 requests outstanding -> next cycle count=0, fetch_rvalid=0, rr_ptr=3; first grant after reset goes to the lowest requesting core.

Source files
------------

// File: rtl/imem_fetch_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// imem_fetch_arbiter_pkg
// Shared parameters and types for the instruction-memory fetch arbiter.
//   NUM_SIMD_CORES  : number of fetch units sharing the IMEM port
//   LOG2_SIMD_CORES : width of a core ID
//   MAX_OUTSTANDING : depth of the in-flight ID FIFO (power of two, >= 2)
// -----------------------------------------------------------------------------
package imem_fetch_arbiter_pkg;

  localparam int NUM_SIMD_CORES  = 4;
  localparam int LOG2_SIMD_CORES = 2;
  localparam int MAX_OUTSTANDING = 4;

  // FIFO pointer width and occupancy counter width (counter must reach MAX).
  localparam int FIFO_PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int FIFO_CNT_W = FIFO_PTR_W + 1;

  typedef logic [LOG2_SIMD_CORES-1:0] core_id_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } fetch_rsp_t;

endpackage

// File: rtl/imem_fetch_arbiter_if.sv
// -----------------------------------------------------------------------------
// imem_fetch_arbiter_if
// Bundles the per-core fetch ports and the single IMEM port.
//   fetch_req/fetch_addr       : core requests (held until granted)
//   fetch_gnt                  : one-hot grant, same cycle as the memory fire
//   fetch_rvalid/fetch_rdata   : routed instruction return, one-hot
//   mem_req_valid/ready/addr   : request channel to IMEM
//   mem_rvalid/mem_rdata       : in-order read response from IMEM
//   protocol_error             : sticky, response with nothing outstanding
// Modports: slave = arbiter side, master = cores + memory side.
// -----------------------------------------------------------------------------
interface imem_fetch_arbiter_if;
  import imem_fetch_arbiter_pkg::*;

  logic [NUM_SIMD_CORES-1:0] fetch_req;
  logic [31:0]               fetch_addr  [NUM_SIMD_CORES];
  logic [NUM_SIMD_CORES-1:0] fetch_gnt;
  logic [NUM_SIMD_CORES-1:0] fetch_rvalid;
  logic [31:0]               fetch_rdata [NUM_SIMD_CORES];
  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic [31:0]               mem_addr;
  logic                      mem_rvalid;
  logic [31:0]               mem_rdata;
  logic                      protocol_error;

  modport slave (
    input  fetch_req, fetch_addr, mem_req_ready, mem_rvalid, mem_rdata,
    output fetch_gnt, fetch_rvalid, fetch_rdata, mem_req_valid, mem_addr,
           protocol_error
  );

  modport master (
    output fetch_req, fetch_addr, mem_req_ready, mem_rvalid, mem_rdata,
    input  fetch_gnt, fetch_rvalid, fetch_rdata, mem_req_valid, mem_addr,
           protocol_error
  );

endinterface

// File: rtl/imem_fetch_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// imem_fetch_arbiter_rr_arbiter
// Combinational round-robin selector. Scans requesters starting one past
// i_ptr (wrapping) and picks the first active one.
//   i_req : request vector
//   i_ptr : last served index
//   o_gnt : one-hot selection (zero when no request)
//   o_sel : encoded selection (zero when no request)
// -----------------------------------------------------------------------------
module imem_fetch_arbiter_rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_sel
);

  logic         w_found;
  logic [W-1:0] w_idx;

  always_comb begin
    o_gnt   = '0;
    o_sel   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    // Offset 1..N so the last-served core is considered last.
    for (int k = 1; k <= N; k++) begin
      w_idx = W'((int'(i_ptr) + k) % N);
      if (!w_found && i_req[w_idx]) begin
        w_found      = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_sel        = w_idx;
      end
    end
  end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// imem_fetch_arbiter
// Shares one IMEM port among the SIMD cores' fetch units. At most one request
// is issued per cycle (round-robin, work-conserving); issued core IDs are
// queued in order and each returning word is routed to its requester one
// cycle after mem_rvalid.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : imem_fetch_arbiter_if.slave (fetch ports + IMEM port)
// -----------------------------------------------------------------------------
module imem_fetch_arbiter
  import imem_fetch_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  imem_fetch_arbiter_if.slave  bus
);

  core_id_t                  r_rr_ptr;
  logic [FIFO_PTR_W-1:0]     r_head;
  logic [FIFO_PTR_W-1:0]     r_tail;
  logic [FIFO_CNT_W-1:0]     r_count;
  core_id_t                  r_id_mem [MAX_OUTSTANDING];
  fetch_rsp_t                r_rsp    [NUM_SIMD_CORES];
  logic                      r_protocol_error;

  logic                      w_can_issue;
  logic                      w_req_valid;
  logic                      w_fire;
  logic                      w_pop;
  logic                      w_spurious;
  logic [NUM_SIMD_CORES-1:0] w_arb_gnt;
  core_id_t                  w_arb_sel;
  core_id_t                  w_head_id;

  imem_fetch_arbiter_rr_arbiter #(
    .N (NUM_SIMD_CORES),
    .W (LOG2_SIMD_CORES)
  ) u_rr (
    .i_req (bus.fetch_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_arb_gnt),
    .o_sel (w_arb_sel)
  );

  // Occupancy before this cycle's pop: a returning word does not free a slot
  // for a request in the same cycle.
  assign w_can_issue = (r_count < FIFO_CNT_W'(MAX_OUTSTANDING));
  assign w_req_valid = w_can_issue && (|bus.fetch_req);
  assign w_fire      = w_req_valid && bus.mem_req_ready;
  assign w_pop       = bus.mem_rvalid && (r_count != '0);
  assign w_spurious  = bus.mem_rvalid && (r_count == '0);
  assign w_head_id   = r_id_mem[r_head];

  assign bus.mem_req_valid  = w_req_valid;
  assign bus.mem_addr       = w_req_valid ? bus.fetch_addr[w_arb_sel] : 32'd0;
  assign bus.fetch_gnt      = w_fire ? w_arb_gnt : '0;
  assign bus.protocol_error = r_protocol_error;

  // ID storage: contents are only meaningful below r_count, so no reset.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      r_id_mem[r_tail] <= w_arb_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr         <= core_id_t'(NUM_SIMD_CORES - 1);
      r_head           <= '0;
      r_tail           <= '0;
      r_count          <= '0;
      r_protocol_error <= 1'b0;
      for (int i = 0; i < NUM_SIMD_CORES; i++) begin
        r_rsp[i] <= '0;
      end
    end else begin
      if (w_fire) begin
        r_tail   <= r_tail + 1'b1;   // power-of-two depth: natural wrap
        r_rr_ptr <= w_arb_sel;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      unique case ({w_fire, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_spurious) begin
        r_protocol_error <= 1'b1;
      end
      // Return lanes are single-cycle pulses; idle lanes carry zero data.
      for (int i = 0; i < NUM_SIMD_CORES; i++) begin
        r_rsp[i] <= '0;
      end
      if (w_pop) begin
        r_rsp[w_head_id] <= '{valid: 1'b1, data: bus.mem_rdata};
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_SIMD_CORES; gi++) begin : g_lane
      assign bus.fetch_rvalid[gi] = r_rsp[gi].valid;
      assign bus.fetch_rdata[gi]  = r_rsp[gi].data;
    end
  endgenerate

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_arbiter
// Randomised cores and memory around imem_fetch_arbiter. A reference model
// (pending-request flags, last-served core, in-flight address list) predicts
// grants and pushes each expected return into a scoreboard queue; a separate
// monitor pops and compares whenever fetch_rvalid is presented.
// -----------------------------------------------------------------------------
module tb_imem_fetch_arbiter;
  import imem_fetch_arbiter_pkg::*;

  localparam int NC = NUM_SIMD_CORES;
  localparam int MO = MAX_OUTSTANDING;

  logic clk = 1'b0;
  logic rst = 1'b1;

  imem_fetch_arbiter_if bus ();

  imem_fetch_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          core;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];      // expected returns, issue order
  int          due_q[$];   // cycle at which each return must be visible
  logic [31:0] pend[$];    // addresses accepted by the memory model

  bit          m_req  [NC];
  logic [31:0] m_addr [NC];
  int          m_last;
  int          m_count;
  bit          m_perr;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory contents: fixed word at 0x100, otherwise a scramble of the address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], a[31:16]} ^ 32'h3C3C_A5A5;
  endfunction

  // Monitor: compares each presented return against the scoreboard head.
  always @(negedge clk) begin
    if (bus.fetch_rvalid != '0) begin
      if (sb.size() == 0 || due_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: fetch_rvalid=%b with nothing expected (cycle %0d)",
                 bus.fetch_rvalid, cyc);
      end else begin : g_cmp
        exp_t e;
        int   d;
        e = sb.pop_front();
        d = due_q.pop_front();
        $display("rsp  core %0d data %08h cycle %0d", e.core, bus.fetch_rdata[e.core], cyc);
        check32("rsp_lane",    32'(bus.fetch_rvalid), 32'd1 << e.core);
        check32("rsp_data",    bus.fetch_rdata[e.core], e.data);
        check32("rsp_latency", 32'(cyc), 32'(d));
        for (int c = 0; c < NC; c++) begin
          if (c != e.core) check32("rsp_idle_lane", bus.fetch_rdata[c], 32'd0);
        end
      end
    end else begin
      for (int c = 0; c < NC; c++) check32("idle_rdata", bus.fetch_rdata[c], 32'd0);
    end
  end

  // One clock of stimulus plus reference prediction of the combinational outputs.
  task automatic drive_cycle(input int req_pct, input int rdy_pct, input int rv_pct, input bit spur);
    bit          any_req;
    bit          exp_valid;
    bit          fire;
    bit          pop;
    int          sel;
    exp_t        e;
    @(negedge clk);
    check32("protocol_error", 32'(bus.protocol_error), 32'(m_perr));
    for (int c = 0; c < NC; c++) begin
      if (!m_req[c] && ($urandom_range(99) < req_pct)) begin
        m_req[c]  = 1'b1;
        m_addr[c] = ($urandom & 32'hFFFF_FFF0) | 32'(c << 2);
      end
      bus.fetch_req[c]  = m_req[c];
      bus.fetch_addr[c] = m_addr[c];
    end
    bus.mem_req_ready = ($urandom_range(99) < rdy_pct);
    if (pend.size() > 0 && ($urandom_range(99) < rv_pct)) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = mem_fn(pend.pop_front());
    end else if (spur && pend.size() == 0) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = $urandom;
    end else begin
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
    end
    #1;
    any_req = 1'b0;
    sel     = -1;
    for (int off = 1; off <= NC; off++) begin
      if (sel < 0 && m_req[(m_last + off) % NC]) sel = (m_last + off) % NC;
    end
    any_req   = (sel >= 0);
    exp_valid = (m_count < MO) && any_req;
    fire      = exp_valid && bus.mem_req_ready;
    check32("mem_req_valid", 32'(bus.mem_req_valid), 32'(exp_valid));
    check32("mem_addr",      bus.mem_addr, exp_valid ? m_addr[sel] : 32'd0);
    check32("fetch_gnt",     32'(bus.fetch_gnt), fire ? (32'd1 << sel) : 32'd0);
    pop = bus.mem_rvalid && (m_count > 0);
    if (pop) due_q.push_back(cyc + 1);
    else if (bus.mem_rvalid) m_perr = 1'b1;
    if (fire) begin
      e.core = sel;
      e.data = mem_fn(m_addr[sel]);
      sb.push_back(e);
      pend.push_back(m_addr[sel]);
      $display("gnt  core %0d addr %08h cycle %0d", sel, m_addr[sel], cyc);
      m_last     = sel;
      m_req[sel] = 1'b0;
    end
    m_count = m_count + int'(fire) - int'(pop);
  endtask

  // Memory is reset together with the arbiter: all in-flight work is dropped.
  // Cores keep their pending (ungranted) requests.
  task automatic reset_dut();
    @(negedge clk);
    rst               = 1'b1;
    bus.mem_req_ready = 1'b0;
    bus.mem_rvalid    = 1'b0;
    #1;
    sb.delete();
    due_q.delete();
    pend.delete();
    m_count = 0;
    m_last  = NC - 1;
    m_perr  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check32("rst_fetch_rvalid", 32'(bus.fetch_rvalid), 32'd0);
    check32("rst_protocol_err", 32'(bus.protocol_error), 32'd0);
  endtask

  initial begin
    bus.fetch_req     = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rvalid    = 1'b0;
    bus.mem_rdata     = 32'd0;
    for (int c = 0; c < NC; c++) begin
      bus.fetch_addr[c] = 32'd0;
      m_req[c]          = 1'b0;
      m_addr[c]         = 32'd0;
    end
    repeat (2) @(posedge clk);
    reset_dut();
    #1;
    check32("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check32("rst_fetch_gnt",     32'(bus.fetch_gnt),     32'd0);
    check32("rst_mem_addr",      bus.mem_addr,           32'd0);

    // Single core 2 fetching 0x100, memory answers immediately.
    m_req[2]  = 1'b1;
    m_addr[2] = 32'h100;
    repeat (5) drive_cycle(0, 100, 100, 1'b0);

    // All cores requesting continuously, one-cycle memory.
    repeat (12) drive_cycle(100, 100, 100, 1'b0);
    repeat (8)  drive_cycle(0, 100, 100, 1'b0);

    // Memory stalls responses: FIFO fills, then drains while requests stay up
    // (full FIFO with a same-cycle pop must not grant).
    repeat (8)  drive_cycle(100, 100, 0, 1'b0);
    repeat (10) drive_cycle(100, 100, 100, 1'b0);
    repeat (12) drive_cycle(0, 100, 100, 1'b0);

    // Spurious response, error must stick.
    drive_cycle(0, 100, 100, 1'b1);
    repeat (4)   drive_cycle(0, 100, 100, 1'b0);
    repeat (100) drive_cycle(50, 70, 60, 1'b0);

    // Reset with three requests in flight.
    reset_dut();
    repeat (3) drive_cycle(100, 100, 0, 1'b0);
    reset_dut();
    repeat (4) drive_cycle(100, 100, 100, 1'b0);

    // Random traffic, then drain.
    repeat (300) drive_cycle(60, 70, 55, 1'b0);
    repeat (30)  drive_cycle(0, 100, 100, 1'b0);
    @(negedge clk);
    #1;
    check32("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
